// File: rtl/rib_rr_arbiter_pkg.sv
// Shared definitions for the RIB round-robin arbiter: FSM encodings, grant
// index constants and pipeline hold values.
package rib_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_ERR  = 2'd2
  } arb_state_e;

  localparam int GRANT_W = 2;

  localparam logic [GRANT_W-1:0] GRANT0 = 2'd0;
  localparam logic [GRANT_W-1:0] GRANT1 = 2'd1;
  localparam logic [GRANT_W-1:0] GRANT2 = 2'd2;

  localparam logic HOLD_ENABLE  = 1'b1;
  localparam logic HOLD_DISABLE = 1'b0;

  // Successor of a master index, wrapping at n.
  function automatic logic [GRANT_W-1:0] next_index(logic [GRANT_W-1:0] idx, int n);
    return (int'(idx) >= n - 1) ? '0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/rib_rr_arbiter_rr_pick.sv
// Combinational rotate-priority finder: first set request at or after ptr,
// wrapping past the top index.
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] pos [N];
  logic [N-1:0]     rot;

  // rot[gi] is the request of the master sitting gi places after ptr.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      logic [SUM_W-1:0] sum;
      assign sum     = {1'b0, ptr} + SUM_W'(gi);
      assign pos[gi] = (sum >= SUM_W'(N)) ? sum - SUM_W'(N) : sum;
      assign rot[gi] = |(req & (N'(1) << pos[gi]));
    end
  endgenerate

  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) idx = pos[k][IDX_W-1:0];
    end
  end

  assign valid = |req;

endmodule

// File: rtl/rib_rr_arbiter.sv
// RIB bus arbiter: round-robin grant with transaction locking, abandon
// detection and a timeout watchdog that forces an error ack.
module rib_rr_arbiter
  import rib_rr_arbiter_pkg::*;
#(
  parameter int N_MASTERS   = 3,
  parameter int PARK_MASTER = 1,
  parameter int TIMEOUT     = 256,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] req_i,
  input  logic                 ack_i,
  input  logic                 clr_err_i,
  output logic [GRANT_W-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 hold_flag_o,
  output logic                 err_ack_o,
  output logic                 timeout_o
);

  localparam logic [GRANT_W-1:0]   PARK_IDX = GRANT_W'(PARK_MASTER);
  localparam logic [N_MASTERS-1:0] PARK_BIT = N_MASTERS'(1) << PARK_MASTER;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e          state_reg, state_next;
  logic [GRANT_W-1:0]  grant_reg, grant_next;
  logic [GRANT_W-1:0]  ptr_reg, ptr_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                timeout_reg, timeout_next;

  logic [N_MASTERS-1:0] grant_bit;
  logic [GRANT_W-1:0]   grant_inc;
  logic [N_MASTERS-1:0] pick_req;
  logic [GRANT_W-1:0]   pick_ptr;
  logic [GRANT_W-1:0]   pick_idx;
  logic                 pick_valid;
  logic                 busy;

  assign busy      = (state_reg != ARB_IDLE);
  assign grant_bit = N_MASTERS'(1) << grant_reg;
  assign grant_inc = next_index(grant_reg, N_MASTERS);

  // While busy the finder looks ahead for the successor of the current owner,
  // so an ack can hand the bus over without an idle cycle.
  assign pick_req = (state_reg == ARB_BUSY) ? (req_i & ~grant_bit) : req_i;
  assign pick_ptr = (state_reg == ARB_BUSY) ? grant_inc : ptr_reg;

  rr_pick #(
    .N     (N_MASTERS),
    .IDX_W (GRANT_W)
  ) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ARB_IDLE: begin
        grant_next = PARK_IDX;
        cnt_next   = '0;
        if (pick_valid) begin
          grant_next = pick_idx;
          state_next = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (int'(grant_reg) >= N_MASTERS) begin
          state_next = ARB_IDLE;
          grant_next = PARK_IDX;
          cnt_next   = '0;
        end else if (ack_i) begin
          ptr_next = grant_inc;
          cnt_next = '0;
          if (pick_valid) begin
            grant_next = pick_idx;
          end else begin
            state_next = ARB_IDLE;
            grant_next = PARK_IDX;
          end
        end else if ((req_i & grant_bit) == '0) begin
          state_next = ARB_IDLE;
          grant_next = PARK_IDX;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ARB_ERR;
          cnt_next   = '0;
        end
      end
      ARB_ERR: begin
        ptr_next   = grant_inc;
        cnt_next   = '0;
        state_next = ARB_IDLE;
        grant_next = PARK_IDX;
      end
      default: begin
        state_next = ARB_IDLE;
        grant_next = PARK_IDX;
        cnt_next   = '0;
      end
    endcase
  end

  // Setting on the entry into ERR makes timeout_o rise together with err_ack_o
  // and lets a fresh timeout win over a simultaneous clear.
  always_comb begin
    timeout_next = timeout_reg;
    if (clr_err_i) timeout_next = 1'b0;
    if (state_reg == ARB_BUSY && state_next == ARB_ERR) timeout_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ARB_IDLE;
      grant_reg   <= PARK_IDX;
      ptr_reg     <= '0;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign grant_o     = grant_reg;
  assign busy_o      = busy;
  assign err_ack_o   = (state_reg == ARB_ERR);
  assign timeout_o   = timeout_reg;
  assign hold_flag_o = ((busy && grant_reg != PARK_IDX) || ((req_i & ~PARK_BIT) != '0))
                       ? HOLD_ENABLE : HOLD_DISABLE;

endmodule

// File: doc/rib_rr_arbiter.md
Name: rib_rr_arbiter

Overview:
- Sequential arbiter for the RIB bus. It replaces the fixed-priority combinational grant logic with round-robin arbitration and transaction locking.
- It owns the grant register and a per-transaction timeout watchdog. It drives the grant index consumed by the RIB address/data mux and the pipeline hold flag.
- It sits between the three RIB masters (m0, m1 = instruction fetch, m2) and the existing slave-select mux.

Parameters:
- N_MASTERS, 3: number of requesting masters. The grant index width is 2; values 2..4 are legal.
- PARK_MASTER, 1: master granted while the bus is idle (instruction fetch).
- TIMEOUT, 256: cycles a granted transaction may wait for an ack before the watchdog fires. Legal range is 2..2^CNT_W.
- CNT_W, 8: timeout counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_i  in  N_MASTERS  per-master request (bit k = master k)
- ack_i  in  1  ack of the slave currently selected by grant_o, returned by the mux
- clr_err_i  in  1  clears sticky timeout_o
- grant_o  out  2  index of the master connected to the slave mux
- busy_o  out  1  a locked transaction is in progress
- hold_flag_o  out  1  pipeline stall request
- err_ack_o  out  1  one-cycle forced ack to the granted master on timeout; the mux ORs it into that master's ack
- timeout_o  out  1  sticky watchdog-fired flag

Behaviour:
- Reset values: grant_o=PARK_MASTER, busy_o=0, hold_flag_o=0, err_ack_o=0, timeout_o=0. Reset also sets the RR pointer to 0, the counter to 0 and the state to IDLE.
- Any cycle with rst=1 returns to these values, including mid-transaction. No ack is synthesised for an aborted transaction.
- States: IDLE, BUSY, ERR (encoded 2 bits).
- Winner search: the first set bit of req_i, scanning from index ptr upward with wrap (ptr, ptr+1, ..., N_MASTERS-1, 0, ...).
- IDLE:
  - grant_o = PARK_MASTER and busy_o = 0.
  - If req_i != 0, register grant_o = winner and go to BUSY. Grant appears 1 cycle after the request.
  - If req_i[PARK_MASTER] is the winner, the same transition applies (locked like any other master).
- BUSY:
  - grant_o is held constant and the counter increments each cycle.
  - ack_i=1: set ptr = (grant_o+1) mod N_MASTERS and clear the counter.
    - If other requests are pending, re-arbitrate in the same cycle with the new ptr. The next grant is registered directly with no idle bubble, and the state stays BUSY.
    - Otherwise go to IDLE.
  - req_i[grant_o] falls with no ack: the master abandoned the transaction. Go to IDLE, leave ptr unchanged and clear the counter.
  - counter == TIMEOUT-1 with no ack: go to ERR.
- ERR, one cycle:
  - err_ack_o = 1 and timeout_o is set.
  - ptr advances as if an ack had occurred, the counter clears, and the state goes to IDLE.
- timeout_o is sticky until clr_err_i=1. If clr_err_i and a new timeout occur in the same cycle, the set wins.
- ack_i is ignored in IDLE and ERR.
- hold_flag_o (combinational) = 1 when any of the following holds:
  - busy_o=1 and grant_o != PARK_MASTER; or
  - any req_i bit other than PARK_MASTER is set.
- Requests arriving while BUSY wait; a non-granted master is never starved beyond N_MASTERS-1 transactions.
- Out-of-range grant encodings are unreachable; if decoded, they force IDLE.

Decomposition:
- Shared package/defines: state encodings (ARB_IDLE, ARB_BUSY, ARB_ERR), grant index constants grant0..grant2, and the existing HoldEnable/HoldDisable values.
- One sub-module: rr_pick (combinational rotate-priority finder). Inputs req and ptr; outputs idx and valid. It is reused for future DMA/peripheral arbiters.
- rib is modified to take grant_o and err_ack_o from this block and to drop its internal grant logic.

Test Plan:
- Reset, then req_i=000 -> grant_o=1, busy_o=0, hold_flag_o=0. Next, req_i=010 -> BUSY with grant_o=1 after 1 cycle; hold_flag_o stays 0.
- req_i=101 constant, slave acks 2 cycles after each grant -> grants alternate 0,2,0,2 back-to-back with no idle cycle; hold_flag_o=1 throughout.
- req_i=111 constant, immediate acks, ptr starting at 0 -> grant sequence 0,1,2,0; each master is served within 3 transactions.
- Grant m2, ack_i held 0, TIMEOUT=8 -> err_ack_o pulses on cycle 8 of BUSY, timeout_o=1 and stays set; clr_err_i pulse -> timeout_o=0.
- Grant m0, then drop req_i[0] after 2 cycles without ack -> IDLE next cycle, grant_o=1, ptr unchanged. A following req_i=101 grants m0 first.
- Assert rst for 1 cycle while BUSY with grant_o=2 -> next cycle grant_o=1, busy_o=0, err_ack_o=0, timeout_o=0.
